spi_regfile_peripheral: RTL and testbench

SPI_REGFILE_PERIPHERAL -- requirements
Module: spi_regfile_peripheral

---
 rtl/spi_pkg.sv | 7 +
 rtl/spi_regfile_peripheral_if.sv | 14 +
 rtl/spi_sync3.sv | 21 ++
 rtl/spi_regfile_peripheral.sv | 114 +++++++++++
 tb/tb_spi_regfile_peripheral.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and frame-width helper for the SPI register-file peripheral
package spi_pkg;
   typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;
   function automatic int frame_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction
endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// spi_regfile_peripheral_if: SPI pins plus register-file status outputs of the peripheral
interface spi_regfile_peripheral_if #(
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 5,
   parameter int ERR_W    = 8
);
   logic                       ncs, sclk, copi, cipo, cipo_oe, wr_stb, busy;
   logic [NUM_REGS*DATA_W-1:0] regs_out;
   logic [ADDR_W-1:0]          wr_addr;
   logic [ERR_W-1:0]           err_cnt;
   modport master (output ncs, sclk, copi, input cipo, cipo_oe, regs_out, wr_stb, wr_addr, busy, err_cnt);
   modport slave (input ncs, sclk, copi, output cipo, cipo_oe, regs_out, wr_stb, wr_addr, busy, err_cnt);
endinterface

// File: rtl/spi_sync3.sv
// spi_sync3: 2-flop synchroniser plus a third flop for edge detection on one SPI input
module spi_sync3 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);
   logic [2:0] s_q;
   // shift the asynchronous input through three flops, reset to the line's idle level
   always_ff @(posedge clk) begin
      if (!rst_n) s_q <= {3{RST_VAL}};
      else s_q <= {s_q[1:0], d_i};
   end
   assign q_o    = s_q[1];
   assign rise_o = s_q[1] & ~s_q[2];
   assign fall_o = ~s_q[1] & s_q[2];
endmodule

// File: rtl/spi_regfile_peripheral.sv
// spi_regfile_peripheral: mode-0 SPI peripheral exposing a small write/read register file
module spi_regfile_peripheral
   import spi_pkg::*;
#(
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 5,
   parameter int ERR_W    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   spi_regfile_peripheral_if.slave  spi
);
   localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
   localparam int CMD_W   = 1 + ADDR_W;
   localparam int CW      = $clog2(FRAME_W + 1);
   state_t                     state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [FRAME_W-1:0]         sh_q, sh_d;
   logic [DATA_W-1:0]          out_q, out_d;
   logic [ADDR_W-1:0]          addr_q, addr_d, wr_addr_q, wr_addr_d;
   logic                       rw_q, rw_d, ovr_q, ovr_d, wr_stb_q, wr_stb_d;
   logic [ERR_W-1:0]           err_q, err_d;
   logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
   logic                       ncs_s, ncs_r, ncs_f, sclk_s, sclk_r, sclk_f, copi_s, copi_r, copi_f;
   logic                       unused_ok;
   spi_sync3 #(.RST_VAL(1'b1)) u_ncs (.clk(clk), .rst_n(rst_n), .d_i(spi.ncs), .q_o(ncs_s), .rise_o(ncs_r), .fall_o(ncs_f));
   spi_sync3 #(.RST_VAL(1'b0)) u_sclk (.clk(clk), .rst_n(rst_n), .d_i(spi.sclk), .q_o(sclk_s), .rise_o(sclk_r), .fall_o(sclk_f));
   spi_sync3 #(.RST_VAL(1'b0)) u_copi (.clk(clk), .rst_n(rst_n), .d_i(spi.copi), .q_o(copi_s), .rise_o(copi_r), .fall_o(copi_f));
   assign unused_ok = ^{ncs_s, sclk_s, copi_r, copi_f, sh_q[FRAME_W-1]};
   // frame sequencing: ncs edges take priority over sclk edges; commit or count errors on ncs release
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      out_d     = out_q;
      addr_d    = addr_q;
      rw_d      = rw_q;
      ovr_d     = ovr_q;
      regs_d    = regs_q;
      wr_addr_d = wr_addr_q;
      wr_stb_d  = 1'b0;
      err_d     = err_q;
      if (state_q != IDLE && ncs_r) begin
         state_d = IDLE;
         if (cnt_q != CW'(FRAME_W) || ovr_q) err_d = err_q + ERR_W'(err_q != '1);
         else if (rw_q)
            for (int i = 0; i < NUM_REGS; i++)
               if (ADDR_W'(i) == addr_q) begin
                  regs_d[i*DATA_W +: DATA_W] = sh_q[DATA_W-1:0];
                  wr_addr_d = addr_q;
                  wr_stb_d  = 1'b1;
               end
      end else if (state_q == IDLE && ncs_f) begin
         state_d = CMD;
         cnt_d   = '0;
         ovr_d   = 1'b0;
      end else if (state_q == DONE && sclk_r) begin
         ovr_d = 1'b1;
      end else if (state_q != IDLE && state_q != DONE) begin
         if (sclk_r) begin
            sh_d  = {sh_q[FRAME_W-2:0], copi_s};
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(CMD_W)) begin
               rw_d    = sh_d[ADDR_W];
               addr_d  = sh_d[ADDR_W-1:0];
               state_d = sh_d[ADDR_W] ? WDATA : RDATA;
               out_d   = '0;
               for (int i = 0; i < NUM_REGS; i++)
                  if (ADDR_W'(i) == sh_d[ADDR_W-1:0]) out_d = regs_q[i*DATA_W +: DATA_W];
            end
            if (cnt_d == CW'(FRAME_W)) state_d = DONE;
         end else if (sclk_f && state_q == RDATA && cnt_q != CW'(CMD_W)) begin
            // the falling edge right after the last address bit must keep the MSB on cipo
            out_d = {out_q[DATA_W-2:0], 1'b0};
         end
      end
   end
   // state and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sh_q      <= '0;
         out_q     <= '0;
         addr_q    <= '0;
         rw_q      <= 1'b0;
         ovr_q     <= 1'b0;
         regs_q    <= '0;
         wr_addr_q <= '0;
         wr_stb_q  <= 1'b0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         out_q     <= out_d;
         addr_q    <= addr_d;
         rw_q      <= rw_d;
         ovr_q     <= ovr_d;
         regs_q    <= regs_d;
         wr_addr_q <= wr_addr_d;
         wr_stb_q  <= wr_stb_d;
         err_q     <= err_d;
      end
   end
   assign spi.cipo_oe  = state_q == RDATA;
   assign spi.cipo     = spi.cipo_oe & out_q[DATA_W-1];
   assign spi.busy     = state_q != IDLE;
   assign spi.regs_out = regs_q;
   assign spi.wr_stb   = wr_stb_q;
   assign spi.wr_addr  = wr_addr_q;
   assign spi.err_cnt  = err_q;
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// tb_spi_regfile_peripheral: directed SPI frames with a scoreboard for commits and read data
module tb_spi_regfile_peripheral;
   localparam int AW = 7, DW = 8, NR = 5, EW = 8, H = 6;
   logic clk, rst_n;
   int tests = 0, fails = 0, leak = 0, rcnt = 0;
   logic [DW-1:0] rval = '0;
   logic sclk_p = 1'b0, ncs_p = 1'b1;
   logic [AW+DW-1:0] cq[$];
   logic [DW-1:0] rq[$];
   spi_regfile_peripheral_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .ERR_W(EW)) bus ();
   spi_regfile_peripheral #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .ERR_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .spi(bus));
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      bus.ncs = 1'b1;
      bus.sclk = 1'b0;
      bus.copi = 1'b0;
      cyc(4);
      rst_n = 1'b1;
      cyc(2);
   endtask
   task automatic xfer(input logic [31:0] f, input int n, input int rst_at);
      bus.ncs = 1'b0;
      cyc(H);
      chk("busy_in_frame", bus.busy, 1);
      for (int i = n - 1; i >= 0; i--) begin
         bus.copi = f[i];
         cyc(H);
         bus.sclk = 1'b1;
         cyc(H);
         bus.sclk = 1'b0;
         if (n - i == rst_at) begin
            rst_n = 1'b0;
            cyc(3);
            rst_n = 1'b1;
         end
      end
      cyc(H);
      bus.ncs = 1'b1;
      bus.copi = 1'b0;
      cyc(2 * H);
      chk("busy_after_frame", bus.busy, 0);
   endtask
   // monitor: commits on wr_stb, read bits sampled at sclk rise while cipo_oe, scored at ncs release
   initial forever begin
      logic [AW+DW-1:0] e;
      logic [DW-1:0] er;
      @(negedge clk);
      if (!bus.cipo_oe && bus.cipo) leak++;
      if (bus.wr_stb) begin
         tests++;
         if (cq.size() == 0) begin
            fails++;
            $display("FAIL wr_stb_unexpected: got addr %0h expected no commit", bus.wr_addr);
         end else begin
            e = cq.pop_front();
            if (bus.wr_addr !== e[DW+:AW] || bus.regs_out[int'(e[DW+:AW])*DW +: DW] !== e[DW-1:0]) begin
               fails++;
               $display("FAIL commit: got addr %0h data %0h expected addr %0h data %0h", bus.wr_addr,
                        bus.regs_out[int'(e[DW+:AW])*DW +: DW], e[DW+:AW], e[DW-1:0]);
            end
         end
      end
      if (bus.sclk && !sclk_p && !bus.ncs && bus.cipo_oe) begin
         rval = {rval[DW-2:0], bus.cipo};
         rcnt++;
      end
      if (bus.ncs && !ncs_p) begin
         if (rcnt != 0) begin
            tests++;
            if (rq.size() == 0) begin
               fails++;
               $display("FAIL read_unexpected: got %0d bits value %0h expected no read", rcnt, rval);
            end else begin
               er = rq.pop_front();
               if (rval !== er || rcnt != DW) begin
                  fails++;
                  $display("FAIL read_data: got %0d bits value %0h expected %0d bits value %0h", rcnt, rval, DW, er);
               end
            end
         end
         rcnt = 0;
         rval = '0;
      end
      sclk_p = bus.sclk;
      ncs_p = bus.ncs;
   end
   initial begin
      do_reset();
      chk("rst_regs", bus.regs_out, 0);
      chk("rst_wr_stb", bus.wr_stb, 0);
      chk("rst_wr_addr", bus.wr_addr, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err", bus.err_cnt, 0);
      chk("rst_cipo_oe", bus.cipo_oe, 0);
      chk("rst_cipo", bus.cipo, 0);
      cq.push_back({7'h02, 8'hA5});
      xfer(32'h82A5, 16, -1);
      chk("wr2_regs", bus.regs_out, 40'h00_00_A5_00_00);
      chk("wr2_addr", bus.wr_addr, 2);
      chk("wr2_err", bus.err_cnt, 0);
      cq.push_back({7'h03, 8'h3C});
      xfer(32'h833C, 16, -1);
      rq.push_back(8'h3C);
      xfer(32'h0300, 16, -1);
      chk("rd3_regs", bus.regs_out, 40'h00_3C_A5_00_00);
      chk("rd3_err", bus.err_cnt, 0);
      rq.push_back(8'hA5);
      xfer(32'h0200, 16, -1);
      do_reset();
      xfer(32'h205, 10, -1);
      chk("short_err", bus.err_cnt, 1);
      chk("short_regs", bus.regs_out, 0);
      xfer(32'h102AB, 17, -1);
      chk("long_err", bus.err_cnt, 2);
      chk("long_regs", bus.regs_out, 0);
      do_reset();
      xfer(32'hFF55, 16, -1);
      chk("oob_wr_err", bus.err_cnt, 0);
      chk("oob_wr_regs", bus.regs_out, 0);
      rq.push_back(8'h00);
      xfer(32'h7F00, 16, -1);
      chk("oob_rd_err", bus.err_cnt, 0);
      do_reset();
      xfer(32'h81FF, 16, 12);
      chk("midrst_regs", bus.regs_out, 0);
      do_reset();
      for (int k = 0; k < 255; k++) xfer(32'h1, 1, -1);
      chk("sat_255", bus.err_cnt, 255);
      xfer(32'h1, 1, -1);
      chk("sat_hold", bus.err_cnt, 255);
      cyc(10);
      chk("commit_q_empty", cq.size(), 0);
      chk("read_q_empty", rq.size(), 0);
      chk("cipo_leak", leak, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
